csr_region_bank: RTL and testbench



---
 rtl/csr_region_bank_pkg.sv | 43 ++++
 rtl/csr_timer0.sv | 102 ++++++++++
 rtl/csr_region_bank.sv | 177 +++++++++++++++++
 tb/tb_csr_region_bank.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_region_bank_pkg.sv
// csr_region_bank_pkg: shared types and defaults for the CSR bank.
// FSM states, region map defaults and timer0 word offsets.
package csr_region_bank_pkg;

  typedef enum logic {
    IDLE,
    RESP
  } state_e;

  localparam int NumRegionsDef = 14;
  localparam int RegionBits    = 4;
  localparam int RegionSlots   = 1 << RegionBits;

  localparam int RegionCtrl     = 0;
  localparam int RegionIdent    = 1;
  localparam int RegionUart     = 2;
  localparam int RegionTimer0   = 3;
  localparam int RegionEthmac   = 4;
  localparam int RegionEthphy   = 5;
  localparam int RegionLeds     = 6;
  localparam int RegionSdram    = 7;
  localparam int RegionScratch  = 8;
  localparam int RegionBoot     = 9;
  localparam int RegionSpi      = 10;
  localparam int RegionI2c      = 11;
  localparam int RegionGpio     = 12;
  localparam int RegionPwm      = 13;

  localparam int RegionRegsDef [NumRegionsDef] =
    '{3, 8, 8, 8, 4, 4, 2, 16, 32, 1, 8, 4, 2, 6};

  localparam int TimerRegs = 8;

  localparam logic [2:0] TimerLoadOffset   = 3'd0;
  localparam logic [2:0] TimerReloadOffset = 3'd1;
  localparam logic [2:0] TimerEnOffset     = 3'd2;
  localparam logic [2:0] TimerUpdateOffset = 3'd3;
  localparam logic [2:0] TimerValueOffset  = 3'd4;
  localparam logic [2:0] TimerStatusOffset = 3'd5;
  localparam logic [2:0] TimerPendOffset   = 3'd6;
  localparam logic [2:0] TimerEnableOffset = 3'd7;

endpackage

// File: rtl/csr_timer0.sv
// csr_timer0: LiteX-style down-counting timer with one event.
// Bus writes arrive as a strobe plus word index and byte lanes.
module csr_timer0
  import csr_region_bank_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    wr,
  input  logic [DATA_WIDTH-1:0]   dat_i_s,
  input  logic [DATA_WIDTH/8-1:0] sel,
  input  logic [2:0]              word,
  output logic [DATA_WIDTH-1:0]   rd_dat,
  output logic                    irq
);

  localparam int SW = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] load_q;
  logic [DATA_WIDTH-1:0] reload_q;
  logic [DATA_WIDTH-1:0] value_q;
  logic [DATA_WIDTH-1:0] snap_q;
  logic                  en_q;
  logic                  pend_q;
  logic                  eve_q;
  logic                  pend_d;
  logic                  eve_d;
  logic                  pend_set;
  logic                  pend_clr;

  function automatic logic [DATA_WIDTH-1:0] merge(
    input logic [DATA_WIDTH-1:0] o,
    input logic [DATA_WIDTH-1:0] d,
    input logic [SW-1:0]         s
  );
    logic [DATA_WIDTH-1:0] r;
    r = o;
    for (int b = 0; b < SW; b++)
      if (s[b]) r[8*b +: 8] = d[8*b +: 8];
    return r;
  endfunction

  // event next-state: a reload set beats a same-cycle clear
  always_comb begin
    pend_set = en_q && (value_q == '0);
    pend_clr = wr && (word == TimerPendOffset)
            && sel[0] && dat_i_s[0];
    pend_d   = pend_set | (pend_q & ~pend_clr);
    eve_d    = eve_q;
    if (wr && word == TimerEnableOffset && sel[0])
      eve_d = dat_i_s[0];
  end

  // timer registers, counter and registered irq
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      load_q   <= '0;
      reload_q <= '0;
      value_q  <= '0;
      snap_q   <= '0;
      en_q     <= 1'b0;
      pend_q   <= 1'b0;
      eve_q    <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (wr && word == TimerLoadOffset)
        load_q <= merge(load_q, dat_i_s, sel);
      if (wr && word == TimerReloadOffset)
        reload_q <= merge(reload_q, dat_i_s, sel);
      if (wr && word == TimerEnOffset && sel[0])
        en_q <= dat_i_s[0];
      if (wr && word == TimerUpdateOffset)
        snap_q <= value_q;
      if (!en_q)
        value_q <= load_q;
      else if (value_q == '0)
        value_q <= reload_q;
      else
        value_q <= value_q - 1'b1;
      pend_q <= pend_d;
      eve_q  <= eve_d;
      irq    <= pend_d & eve_d;
    end
  end

  // register read mux
  always_comb begin
    rd_dat = '0;
    case (word)
      TimerLoadOffset:   rd_dat = load_q;
      TimerReloadOffset: rd_dat = reload_q;
      TimerEnOffset:     rd_dat[0] = en_q;
      TimerValueOffset:  rd_dat = snap_q;
      TimerStatusOffset: rd_dat[0] = (value_q == '0);
      TimerPendOffset:   rd_dat[0] = pend_q;
      TimerEnableOffset: rd_dat[0] = eve_q;
      default:           rd_dat = '0;
    endcase
  end

endmodule

// File: rtl/csr_region_bank.sv
// csr_region_bank: Wishbone CSR bank with UART pass-through.
// Define CSR_REGION_BANK_TIMER_EN to host timer0 in TIMER_REGION.
module csr_region_bank
  import csr_region_bank_pkg::*;
#(
  parameter int          NUM_REGIONS = NumRegionsDef,
  parameter int          REGION_REGS [NUM_REGIONS] = RegionRegsDef,
  parameter logic [31:0] BASE_ADDR    = 32'hF000_0000,
  parameter int          REGION_SHIFT = 11,
  parameter int          DATA_WIDTH   = 32,
  parameter int          PT_REGION    = RegionUart,
  parameter int          TIMER_REGION = RegionTimer0
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cyc,
  input  logic                    stb,
  input  logic                    we,
  input  logic [31:0]             addr,
  input  logic [DATA_WIDTH/8-1:0] sel,
  input  logic [DATA_WIDTH-1:0]   dat_i_s,
  output logic [DATA_WIDTH-1:0]   dat_o_s,
  output logic                    ack,
  output logic                    err,
  output logic                    pt_cyc,
  output logic                    pt_stb,
  output logic                    pt_we,
  output logic [2:0]              pt_addr,
  output logic [DATA_WIDTH/8-1:0] pt_sel,
  output logic [DATA_WIDTH-1:0]   pt_dat_o,
  input  logic [DATA_WIDTH-1:0]   pt_dat_i,
  input  logic                    pt_ack,
  output logic                    irq
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int WW = REGION_SHIFT - 2;

  state_e                state_q;
  state_e                state_d;
  logic                  miss_q;
  logic [DATA_WIDTH-1:0] dat_q;
  logic                  ack_int;
  logic                  err_int;

  logic                  base_ok;
  logic [RegionBits-1:0] region;
  logic [WW-1:0]         word;
  logic                  req;
  logic                  pt_hit;
  logic                  pt_act;
  logic                  mapped;
  logic                  accept;
  logic                  wr_en;
  logic [RegionSlots-1:0] size_ok;
  logic [DATA_WIDTH-1:0] rd_reg [RegionSlots];
  logic [DATA_WIDTH-1:0] rd_sel;
  logic                  unused;

  assign base_ok = addr[31:REGION_SHIFT+4]
                == BASE_ADDR[31:REGION_SHIFT+4];
  assign region  = addr[REGION_SHIFT+3:REGION_SHIFT];
  assign word    = addr[REGION_SHIFT-1:2];
  assign req     = cyc & stb;
  assign pt_hit  = base_ok && region == RegionBits'(PT_REGION);
  assign pt_act  = req & pt_hit;
  assign mapped  = base_ok && size_ok[region];
  assign accept  = (state_q == IDLE) && req && !pt_hit;
  assign wr_en   = accept && we && mapped;
  assign rd_sel  = rd_reg[region];
  assign unused  = &{1'b0, addr[1:0]};

  assign pt_cyc   = cyc & pt_hit;
  assign pt_stb   = stb & pt_hit;
  assign pt_we    = we & pt_hit;
  assign pt_addr  = addr[4:2];
  assign pt_sel   = sel;
  assign pt_dat_o = dat_i_s;

  assign ack     = ack_int | (pt_act & pt_ack);
  assign err     = err_int;
  assign dat_o_s = pt_act ? pt_dat_i : dat_q;

  // bus FSM state register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // next state and one-cycle ack/err pulse
  always_comb begin
    state_d = state_q;
    ack_int = 1'b0;
    err_int = 1'b0;
    unique case (state_q)
      IDLE: if (accept) state_d = RESP;
      RESP: begin
        state_d = IDLE;
        ack_int = ~miss_q;
        err_int = miss_q;
      end
      default: state_d = IDLE;
    endcase
  end

  // latch decode result and read data on accept
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      miss_q <= 1'b0;
      dat_q  <= '0;
    end else if (accept) begin
      miss_q <= ~mapped;
      dat_q  <= (mapped && !we) ? rd_sel : '0;
    end
  end

`ifdef CSR_REGION_BANK_TIMER_EN
  logic tmr_irq;
  assign irq = tmr_irq;
`else
  assign irq = 1'b0;
`endif

  for (genvar r = 0; r < RegionSlots; r++) begin : g_reg
    if (r >= NUM_REGIONS || r == PT_REGION) begin : g_none
      assign size_ok[r] = 1'b0;
      assign rd_reg[r]  = '0;
    end
`ifdef CSR_REGION_BANK_TIMER_EN
    else if (r == TIMER_REGION) begin : g_tmr
      assign size_ok[r] = word < WW'(TimerRegs);
      csr_timer0 #(
        .DATA_WIDTH(DATA_WIDTH)
      ) u_timer0 (
        .clock   (clock),
        .reset   (reset),
        .wr      (wr_en && region == RegionBits'(r)),
        .dat_i_s (dat_i_s),
        .sel     (sel),
        .word    (word[2:0]),
        .rd_dat  (rd_reg[r]),
        .irq     (tmr_irq)
      );
    end
`endif
    else begin : g_mem
      localparam int N = REGION_REGS[r];
      logic [DATA_WIDTH-1:0] mem [N];
      logic [DATA_WIDTH-1:0] rd_w;

      assign size_ok[r] = word < WW'(N);
      assign rd_reg[r]  = rd_w;

      // byte-lane register writes
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          for (int w = 0; w < N; w++) mem[w] <= '0;
        end else begin
          for (int w = 0; w < N; w++)
            if (wr_en && region == RegionBits'(r)
                && word == WW'(w))
              for (int b = 0; b < SW; b++)
                if (sel[b])
                  mem[w][8*b +: 8] <= dat_i_s[8*b +: 8];
        end
      end

      // word read mux
      always_comb begin
        rd_w = '0;
        for (int w = 0; w < N; w++)
          if (word == WW'(w)) rd_w = mem[w];
      end
    end
  end

endmodule

// File: tb/tb_csr_region_bank.sv
// tb_csr_region_bank: vector table plus scoreboard for the CSR bank.
// Timer sequences run when CSR_REGION_BANK_TIMER_EN is defined.
module tb_csr_region_bank;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = '0;
  logic [3:0]  sel = '0;
  logic [31:0] dat_i_s = '0;
  logic [31:0] dat_o_s;
  logic        ack;
  logic        err;
  logic        pt_cyc;
  logic        pt_stb;
  logic        pt_we;
  logic [2:0]  pt_addr;
  logic [3:0]  pt_sel;
  logic [31:0] pt_dat_o;
  logic [31:0] pt_dat_i = '0;
  logic        pt_ack = 1'b0;
  logic        irq;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic        exp_ack;
    logic        exp_err;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t tbl[$];
  vec_t sb_q[$];

  csr_region_bank dut (
    .clock    (clock),
    .reset    (reset),
    .cyc      (cyc),
    .stb      (stb),
    .we       (we),
    .addr     (addr),
    .sel      (sel),
    .dat_i_s  (dat_i_s),
    .dat_o_s  (dat_o_s),
    .ack      (ack),
    .err      (err),
    .pt_cyc   (pt_cyc),
    .pt_stb   (pt_stb),
    .pt_we    (pt_we),
    .pt_addr  (pt_addr),
    .pt_sel   (pt_sel),
    .pt_dat_o (pt_dat_o),
    .pt_dat_i (pt_dat_i),
    .pt_ack   (pt_ack),
    .irq      (irq)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(
    input logic w, input logic [31:0] a, input logic [3:0] s,
    input logic [31:0] d, input logic ea, input logic ee,
    input logic [31:0] ed
  );
    vec_t v;
    v.we = w; v.addr = a; v.sel = s; v.dat = d;
    v.exp_ack = ea; v.exp_err = ee; v.exp_dat = ed;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // drive one request, drop cyc right after accept, check response
  task automatic issue(input vec_t v);
    vec_t e;
    bit   seen;
    cyc = 1'b1; stb = 1'b1; we = v.we;
    addr = v.addr; sel = v.sel; dat_i_s = v.dat;
    sb_q.push_back(v);
    tick();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4 && !seen; i++) begin
      if (ack || err) seen = 1'b1;
      else tick();
    end
    e = sb_q.pop_front();
    if (!seen) begin
      chk("resp_timeout", 32'd0, 32'd1);
    end else begin
      chk("ack", {31'd0, ack}, {31'd0, e.exp_ack});
      chk("err", {31'd0, err}, {31'd0, e.exp_err});
      chk("pt_stb_idle", {31'd0, pt_stb}, 32'd0);
      if (!e.we) chk("rdata", dat_o_s, e.exp_dat);
    end
    tick();
    chk("ack_one_cycle", {30'd0, ack, err}, 32'd0);
  endtask

  task automatic bus_pulse(input logic [31:0] a, input logic [31:0] d);
    cyc = 1'b1; stb = 1'b1; we = 1'b1;
    addr = a; sel = 4'hF; dat_i_s = d;
    tick();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  initial begin
    tbl.push_back(mk(1, 32'hF000_0004, 4'hF, 32'hDEADBEEF, 1, 0, 0));
    tbl.push_back(mk(0, 32'hF000_0004, 4'hF, 0, 1, 0, 32'hDEADBEEF));
    tbl.push_back(mk(1, 32'hF000_0008, 4'hF, 32'h11223344, 1, 0, 0));
    tbl.push_back(mk(1, 32'hF000_0008, 4'b0010, 32'h0000AB00, 1, 0, 0));
    tbl.push_back(mk(0, 32'hF000_0008, 4'hF, 0, 1, 0, 32'h1122AB44));
    tbl.push_back(mk(0, 32'hF000_0010, 4'hF, 0, 0, 1, 32'h0));
    tbl.push_back(mk(1, 32'hE000_0000, 4'hF, 32'h55555555, 0, 1, 0));
    tbl.push_back(mk(0, 32'hF000_0000, 4'hF, 0, 1, 0, 32'h0));
    tbl.push_back(mk(0, 32'hF000_0004, 4'hF, 0, 1, 0, 32'hDEADBEEF));
    tbl.push_back(mk(1, 32'hF000_4000, 4'b1001, 32'hA5A5A5A5, 1, 0, 0));
    tbl.push_back(mk(0, 32'hF000_4000, 4'hF, 0, 1, 0, 32'hA50000A5));
    tbl.push_back(mk(1, 32'hF000_407C, 4'hF, 32'h12345678, 1, 0, 0));
    tbl.push_back(mk(0, 32'hF000_407C, 4'hF, 0, 1, 0, 32'h12345678));
    tbl.push_back(mk(0, 32'hF000_4804, 4'hF, 0, 0, 1, 32'h0));
    tbl.push_back(mk(0, 32'hF000_7000, 4'hF, 0, 0, 1, 32'h0));
    tbl.push_back(mk(0, 32'hF000_7800, 4'hF, 0, 0, 1, 32'h0));
    tbl.push_back(mk(1, 32'hF000_6814, 4'hF, 32'h0000CAFE, 1, 0, 0));
    tbl.push_back(mk(1, 32'hF000_6818, 4'hF, 32'h0000BEEF, 0, 1, 0));
    tbl.push_back(mk(0, 32'hF000_6814, 4'hF, 0, 1, 0, 32'h0000CAFE));
    tbl.push_back(mk(0, 32'hF000_6818, 4'hF, 0, 0, 1, 32'h0));

    // reset values while reset is held
    tick();
    tick();
    chk("rst_ack", {31'd0, ack}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_dat", dat_o_s, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_pt", {29'd0, pt_cyc, pt_stb, pt_we}, 32'd0);
    reset = 1'b1;
    tick();
    chk("post_rst_ack", {30'd0, ack, err}, 32'd0);

    foreach (tbl[i]) issue(tbl[i]);

    // pass-through read with a late pt_ack
    pt_dat_i = 32'hCAFEF00D;
    cyc = 1'b1; stb = 1'b1; we = 1'b0;
    addr = 32'hF000_1008; sel = 4'hF;
    #1;
    chk("pt_stb", {31'd0, pt_stb}, 32'd1);
    chk("pt_cyc", {31'd0, pt_cyc}, 32'd1);
    chk("pt_we", {31'd0, pt_we}, 32'd0);
    chk("pt_addr", {29'd0, pt_addr}, 32'd2);
    chk("pt_sel", {28'd0, pt_sel}, 32'hF);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("pt_wait_ack", {30'd0, ack, err}, 32'd0);
    end
    pt_ack = 1'b1;
    #1;
    chk("pt_ack", {31'd0, ack}, 32'd1);
    chk("pt_rdata", dat_o_s, 32'hCAFEF00D);
    tick();
    cyc = 1'b0; stb = 1'b0; pt_ack = 1'b0;
    #1;
    chk("pt_release", {30'd0, ack, pt_stb}, 32'd0);

    // pass-through write forwards data and we
    cyc = 1'b1; stb = 1'b1; we = 1'b1;
    addr = 32'hF000_1014; dat_i_s = 32'h0BADC0DE;
    #1;
    chk("pt_we_w", {31'd0, pt_we}, 32'd1);
    chk("pt_dat_o", pt_dat_o, 32'h0BADC0DE);
    chk("pt_addr_w", {29'd0, pt_addr}, 32'd5);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick();
    issue(mk(0, 32'hF000_4000, 4'hF, 0, 1, 0, 32'hA50000A5));

    // reset asserted while ack is high aborts the response
    cyc = 1'b1; stb = 1'b1; we = 1'b1;
    addr = 32'hF000_0000; sel = 4'hF; dat_i_s = 32'h77;
    tick();
    chk("pre_abort_ack", {31'd0, ack}, 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_ack", {30'd0, ack, err}, 32'd0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    tick();
    chk("abort_hold", {31'd0, ack}, 32'd0);
    chk("abort_dat", dat_o_s, 32'd0);
    reset = 1'b1;
    tick();
    issue(mk(1, 32'hF000_0008, 4'hF, 32'h600DF00D, 1, 0, 0));
    issue(mk(0, 32'hF000_0008, 4'hF, 0, 1, 0, 32'h600DF00D));

`ifdef CSR_REGION_BANK_TIMER_EN
    issue(mk(1, 32'hF000_1800, 4'hF, 32'd5, 1, 0, 0));
    issue(mk(1, 32'hF000_1804, 4'hF, 32'd3, 1, 0, 0));
    issue(mk(1, 32'hF000_181C, 4'hF, 32'd1, 1, 0, 0));
    issue(mk(0, 32'hF000_181C, 4'hF, 0, 1, 0, 32'd1));
    issue(mk(0, 32'hF000_1800, 4'hF, 0, 1, 0, 32'd5));
    bus_pulse(32'hF000_1808, 32'd1);
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("irq_k%0d", k), {31'd0, irq},
          {31'd0, k == 6});
    end
    tick();
    bus_pulse(32'hF000_1818, 32'd1);
    chk("irq_cleared", {31'd0, irq}, 32'd0);
    tick();
    chk("irq_k9", {31'd0, irq}, 32'd0);
    tick();
    chk("irq_k10", {31'd0, irq}, 32'd1);
    tick();
    tick();
    tick();
    bus_pulse(32'hF000_1818, 32'd1);
    chk("irq_set_wins", {31'd0, irq}, 32'd1);
    tick();
    bus_pulse(32'hF000_1818, 32'd1);
    chk("irq_clear2", {31'd0, irq}, 32'd0);
`else
    issue(mk(1, 32'hF000_1804, 4'hF, 32'h0BADF00D, 1, 0, 0));
    issue(mk(0, 32'hF000_1804, 4'hF, 0, 1, 0, 32'h0BADF00D));
    issue(mk(0, 32'hF000_181C, 4'hF, 0, 1, 0, 32'h0));
    chk("irq_tied", {31'd0, irq}, 32'd0);
`endif

    chk("sb_empty", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
